// File: rtl/io_bank.sv
// io_bank: memory-mapped GPIO, timer with compare IRQ and 8N1 UART TX.
// Read data is combinational from pre-edge state; writes land on the edge.
module io_bank #(
  parameter int CLK_DIV  = 104,
  parameter int GPIO_W   = 8,
  parameter int FIFO_LOG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              timer_irq
);
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int BW    = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [5:0] sel;
  logic       wr;
  logic       unused_addr;
  assign sel         = io_addr[7:2];
  assign wr          = io_en & io_we;
  assign unused_addr = ^io_addr[1:0];

  logic wr_gpio, wr_cmp, wr_tstat, wr_tx, wr_ustat;
  assign wr_gpio  = wr && (sel == 6'd0);
  assign wr_cmp   = wr && (sel == 6'd3);
  assign wr_tstat = wr && (sel == 6'd4);
  assign wr_tx    = wr && (sel == 6'd5);
  assign wr_ustat = wr && (sel == 6'd6);

  logic [GPIO_W-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_gpio) gpio_out <= io_data_write[GPIO_W-1:0];
    end
  end

  logic [31:0] counter, compare;
  logic        flag;

  // A compare hit on the same edge as a W1C keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      compare <= '1;
      flag    <= 1'b0;
    end else begin
      counter <= counter + 32'd1;
      if (wr_cmp) compare <= io_data_write;
      if (counter == compare) flag <= 1'b1;
      else if (wr_tstat && io_data_write[0]) flag <= 1'b0;
    end
  end
  assign timer_irq = flag;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_LOG-1:0] wp, rp;
  logic [FIFO_LOG:0]   cnt;
  logic                full, empty, push, pop, ovf;

  assign full  = cnt == (FIFO_LOG+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push  = wr_tx & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= io_data_write[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      if (wr_tx && full) ovf <= 1'b1;
      else if (wr_ustat && io_data_write[3]) ovf <= 1'b0;
    end
  end

  state_t      st, ns;
  logic [BW-1:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic        bit_end;

  assign bit_end = baud == BW'(CLK_DIV - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= ns;
  end

  always_comb begin
    ns  = st;
    pop = 1'b0;
    unique case (st)
      IDLE: if (!empty) begin
        ns  = START;
        pop = 1'b1;
      end
      START: if (bit_end) ns = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) ns = STOP;
      STOP: if (bit_end) begin
        if (!empty) begin
          ns  = START;
          pop = 1'b1;
        end else begin
          ns = IDLE;
        end
      end
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud    <= '0;
      bit_idx <= '0;
      shifter <= '0;
    end else if (pop) begin
      shifter <= mem[rp];
      baud    <= '0;
      bit_idx <= '0;
    end else if (st != IDLE) begin
      if (bit_end) begin
        baud <= '0;
        if (st == DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        baud <= baud + 1'b1;
      end
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (st)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shifter[bit_idx];
      default: uart_tx = 1'b1;
    endcase
  end

  logic busy;
  assign busy = st != IDLE;

  always_comb begin
    io_data_read = '0;
    if (io_en) begin
      unique case (1'b1)
        sel == 6'd0: io_data_read = 32'(gpio_out);
        sel == 6'd1: io_data_read = 32'(sync2);
        sel == 6'd2: io_data_read = counter;
        sel == 6'd3: io_data_read = compare;
        sel == 6'd4: io_data_read = {31'd0, flag};
        sel == 6'd6: io_data_read = {28'd0, ovf, busy, empty, full};
        default:     io_data_read = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: directed self-checking bench for io_bank with CLK_DIV=4.
// Inputs change 1ns after rising edges; outputs are sampled mid-cycle.
module tb_io_bank;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  io_addr = '0;
  logic        io_en = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] io_data_write = '0;
  logic [31:0] io_data_read;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        uart_tx;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] cmpv;

  always #5 clk = ~clk;

  io_bank #(.CLK_DIV(4), .GPIO_W(8), .FIFO_LOG(2)) dut (
    .clk(clk),
    .reset(reset),
    .io_addr(io_addr),
    .io_en(io_en),
    .io_we(io_we),
    .io_data_write(io_data_write),
    .io_data_read(io_data_read),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .uart_tx(uart_tx),
    .timer_irq(timer_irq)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = a;
    io_data_write = d;
    @(posedge clk);
    #1;
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = a;
    #1;
    d = io_data_read;
    io_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #2;
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx: got %b want 1", uart_tx);
    end
    checks++;
    if (gpio_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_gpio: got %h want 00", gpio_out);
    end
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: got %b want 0", timer_irq);
    end
    step(2);
    reset = 1'b0;
    step(1);
    rd(8'h18, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL rst_ustat: got %h want 2", d);
    end
    rd(8'h0C, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rst_cmp: got %h want ffffffff", d);
    end
    rd(8'h10, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_tstat: got %h want 0", d);
    end
  endtask

  task automatic test_gpio;
    logic [31:0] d;
    wr(8'h00, 32'hA5);
    checks++;
    if (gpio_out !== 8'hA5) begin
      errors++;
      $display("FAIL gpio_out: got %h want a5", gpio_out);
    end
    rd(8'h00, d);
    checks++;
    if (d !== 32'hA5) begin
      errors++;
      $display("FAIL gpio_rd: got %h want a5", d);
    end
    gpio_in = 8'h3C;
    step(1);
    rd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL gpio_in_1: got %h want 0", d);
    end
    step(1);
    rd(8'h04, d);
    checks++;
    if (d !== 32'h3C) begin
      errors++;
      $display("FAIL gpio_in_2: got %h want 3c", d);
    end
    rd(8'h40, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped: got %h want 0", d);
    end
    wr(8'h00, 32'hFFFF_FF5A);
    rd(8'h00, d);
    checks++;
    if (d !== 32'h5A) begin
      errors++;
      $display("FAIL gpio_upper: got %h want 5a", d);
    end
  endtask

  task automatic test_timer;
    logic [31:0] c, d;
    rd(8'h08, c);
    wr(8'h0C, c + 32'd10);
    step(9);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b want 0", timer_irq);
    end
    step(1);
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b want 1", timer_irq);
    end
    rd(8'h08, d);
    checks++;
    if (d !== c + 32'd11) begin
      errors++;
      $display("FAIL count: got %h want %h", d, c + 32'd11);
    end
    rd(8'h10, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL tstat: got %h want 1", d);
    end
    wr(8'h10, 32'h0);
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++;
      $display("FAIL w0_noeffect: got %b want 1", timer_irq);
    end
    wr(8'h10, 32'h1);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c: got %b want 0", timer_irq);
    end
    rd(8'h08, c);
    cmpv = c + 32'd5;
    wr(8'h0C, cmpv);
    step(4);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_pre: got %b want 0", timer_irq);
    end
    wr(8'h10, 32'h1);
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b want 1", timer_irq);
    end
    wr(8'h10, 32'h1);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_2: got %b want 0", timer_irq);
    end
  endtask

  task automatic test_bus;
    logic [31:0] c, d;
    io_en = 1'b0;
    io_we = 1'b1;
    io_addr = 8'h00;
    io_data_write = 32'h77;
    #1;
    checks++;
    if (io_data_read !== 32'h0) begin
      errors++;
      $display("FAIL en0_read: got %h want 0", io_data_read);
    end
    @(posedge clk);
    #1;
    io_we = 1'b0;
    checks++;
    if (gpio_out !== 8'h5A) begin
      errors++;
      $display("FAIL en0_write: got %h want 5a", gpio_out);
    end
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = 8'h0C;
    io_data_write = 32'h1234;
    #1;
    checks++;
    if (io_data_read !== cmpv) begin
      errors++;
      $display("FAIL rdw_old: got %h want %h", io_data_read, cmpv);
    end
    @(posedge clk);
    #1;
    io_en = 1'b0;
    io_we = 1'b0;
    rd(8'h0C, d);
    checks++;
    if (d !== 32'h1234) begin
      errors++;
      $display("FAIL rdw_new: got %h want 1234", d);
    end
    rd(8'h08, c);
    wr(8'h08, 32'h0);
    rd(8'h08, d);
    checks++;
    if (d !== c + 32'd1) begin
      errors++;
      $display("FAIL count_ro: got %h want %h", d, c + 32'd1);
    end
  endtask

  task automatic test_uart_frame;
    logic [31:0] d;
    logic [9:0]  fr;
    fr = {1'b1, 8'h41, 1'b0};
    wr(8'h14, 32'h41);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_lat: got %b want 1", uart_tx);
    end
    rd(8'h18, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ustat_queued: got %h want 0", d);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (uart_tx !== fr[k/4]) begin
        errors++;
        $display("FAIL frame_bit%0d: got %b want %b", k, uart_tx, fr[k/4]);
      end
      rd(8'h18, d);
      checks++;
      if (d[2] !== 1'b1) begin
        errors++;
        $display("FAIL busy%0d: got %b want 1", k, d[2]);
      end
    end
    step(1);
    rd(8'h18, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ustat_done: got %h want 2", d);
    end
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] d;
    logic [7:0]  b;
    logic [9:0]  fr;
    for (int i = 1; i <= 6; i++) wr(8'h14, 32'(i));
    rd(8'h18, d);
    checks++;
    if (d !== 32'hD) begin
      errors++;
      $display("FAIL ustat_full: got %h want d", d);
    end
    for (int k = 4; k < 200; k++) begin
      if (k > 4) begin
        @(posedge clk);
        #1;
      end
      io_en = 1'b0;
      io_we = 1'b0;
      b = 8'(k / 40 + 1);
      fr = {1'b1, b, 1'b0};
      checks++;
      if (uart_tx !== fr[(k % 40) / 4]) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b want %b", k, uart_tx,
                 fr[(k % 40) / 4]);
      end
      if (k == 12) begin
        rd(8'h18, d);
        checks++;
        if (d !== 32'h5) begin
          errors++;
          $display("FAIL ovf_clr: got %h want 5", d);
        end
      end
      if (k == 10) begin
        io_en = 1'b1;
        io_we = 1'b1;
        io_addr = 8'h18;
        io_data_write = 32'h8;
      end
    end
    step(1);
    rd(8'h18, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL b2b_done: got %h want 2", d);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got %b want 1", uart_tx);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    wr(8'h14, 32'h55);
    wr(8'h14, 32'h66);
    step(10);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_tx: got %b want 1", uart_tx);
    end
    checks++;
    if (gpio_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_gpio: got %h want 00", gpio_out);
    end
    step(2);
    reset = 1'b0;
    step(1);
    rd(8'h18, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL mid_rst_ustat: got %h want 2", d);
    end
    for (int k = 0; k < 12; k++) begin
      step(1);
      checks++;
      if (uart_tx !== 1'b1) begin
        errors++;
        $display("FAIL mid_rst_idle%0d: got %b want 1", k, uart_tx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_timer();
    test_bus();
    test_uart_frame();
    test_fifo_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
